// File: rtl/bcau_gen.sv
// bcau_gen: brightness/contrast adjust unit. It captures a multi-channel frame,
// accumulates one row per cycle into per-tile sums, and then pushes every
// pixel away from its floor tile average (contrast) or toward it (soften) by a
// runtime delta, with saturation. Valid/ready handshakes on both sides.
module bcau_gen #(
  parameter int CHANNELS = 5,
  parameter int PIX_W    = 8,
  parameter int ROWS     = 4,
  parameter int COLS     = 20,
  parameter int BLK      = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [CHANNELS-1:0][ROWS*COLS-1:0][PIX_W-1:0] in_pixels,
  input  logic [PIX_W-1:0]                              delta,
  input  logic [1:0]                                    mode,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [CHANNELS-1:0][ROWS*COLS-1:0][PIX_W-1:0] out_pixels
);

  localparam int NBLK   = COLS / BLK;
  localparam int SHIFT  = $clog2(ROWS * BLK);
  localparam int ACC_W  = PIX_W + SHIFT;
  localparam int RSUM_W = PIX_W + $clog2(BLK);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IDX_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  localparam logic [1:0] MODE_CONTRAST = 2'b00;
  localparam logic [1:0] MODE_SOFTEN   = 2'b10;

  // Tiles must cover the window exactly and the average must be a pure shift.
  if ((COLS % BLK) != 0 || ((ROWS * BLK) & (ROWS * BLK - 1)) != 0) begin : g_param_check
    $error("bcau_gen: COLS must be a multiple of BLK and ROWS*BLK a power of two");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ADJUST, S_OUT} state_t;
  typedef logic [CHANNELS-1:0][ROWS*COLS-1:0][PIX_W-1:0] frame_t;
  typedef logic [CHANNELS-1:0][NBLK-1:0][ACC_W-1:0]      acc_t;
  typedef logic [CHANNELS-1:0][NBLK-1:0][RSUM_W-1:0]     rsum_t;

  state_t             state_q, state_d;
  frame_t             frame_q;
  acc_t               acc_q;
  rsum_t              row_sum;
  frame_t             adj;
  logic [PIX_W-1:0]   delta_q;
  logic [1:0]         mode_q;
  logic [ROW_W-1:0]   row_q;
  logic [IDX_W-1:0]   idx;

  logic [ACC_W-1:0]   avg_full;
  logic [PIX_W-1:0]   avg;
  logic [PIX_W-1:0]   pix;
  logic [PIX_W:0]     up;
  logic [PIX_W:0]     dn;
  logic [PIX_W-1:0]   sat_up;
  logic [PIX_W-1:0]   sat_dn;

  assign in_ready = (state_q == S_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = S_ACCUM;
      S_ACCUM:  if (row_q == ROW_W'(ROWS - 1)) state_d = S_ADJUST;
      S_ADJUST: state_d = S_OUT;
      S_OUT:    if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Per-channel, per-tile sum of the BLK pixels in the current row.
  always_comb begin
    row_sum = '0;
    idx     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < NBLK; b++) begin
        for (int j = 0; j < BLK; j++) begin
          idx = IDX_W'(int'(row_q) * COLS + b * BLK + j);
          row_sum[c][b] = row_sum[c][b] + RSUM_W'(frame_q[c][idx]);
        end
      end
    end
  end

  // Adjusted pixel values from the finished tile sums and captured controls.
  always_comb begin
    adj      = '0;
    avg_full = '0;
    avg      = '0;
    pix      = '0;
    up       = '0;
    dn       = '0;
    sat_up   = '0;
    sat_dn   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < ROWS * COLS; k++) begin
        avg_full = acc_q[c][(k % COLS) / BLK] >> SHIFT;
        avg      = avg_full[PIX_W-1:0];
        pix      = frame_q[c][k];
        up       = {1'b0, pix} + {1'b0, delta_q};
        dn       = {1'b0, pix} - {1'b0, delta_q};
        sat_up   = up[PIX_W] ? '1 : up[PIX_W-1:0];
        sat_dn   = dn[PIX_W] ? '0 : dn[PIX_W-1:0];
        case (mode_q)
          MODE_CONTRAST: adj[c][k] = (pix > avg) ? sat_up : sat_dn;
          MODE_SOFTEN:   adj[c][k] = (pix > avg) ? sat_dn : sat_up;
          default:       adj[c][k] = pix;
        endcase
      end
    end
  end

  // Datapath: capture, row accumulation, result register and output handshake.
  // NOTE: the captured frame and accumulators are reset explicitly so an
  // aborted frame leaves no stale data behind; this costs reset fan-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      acc_q      <= '0;
      delta_q    <= '0;
      mode_q     <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      out_pixels <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            frame_q <= in_pixels;
            delta_q <= delta;
            mode_q  <= mode;
            acc_q   <= '0;
            row_q   <= '0;
          end
        end
        S_ACCUM: begin
          for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < NBLK; b++) begin
              acc_q[c][b] <= acc_q[c][b] + ACC_W'(row_sum[c][b]);
            end
          end
          row_q <= row_q + ROW_W'(1);
        end
        S_ADJUST: begin
          out_pixels <= adj;
          out_valid  <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bcau_gen.md
Name: bcau_gen

Overview:
Parametrised next-generation brightness/contrast adjust unit. It sits between the image-rotation stage (upstream) and the heuristic stage (downstream). It accepts a frame of CHANNELS windows, each ROWS x COLS pixels, and computes a floor average per ROWS x BLK tile. Each pixel is then pushed away from (or toward) its tile average by a programmable delta, with saturation. Unlike the fixed unit, it adds runtime delta, mode select (contrast/bypass/soften) and true valid/ready back-pressure on both sides.

Parameters:
CHANNELS, 5, number of independent pixel windows processed in parallel
PIX_W, 8, pixel width in bits
ROWS, 4, rows per window (tile height)
COLS, 20, columns per window
BLK, 4, tile width in columns; COLS % BLK == 0 and ROWS*BLK a power of two (elaboration check, $error otherwise)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream frame valid
in_ready  output  1  unit can accept a frame (high only in IDLE)
in_pixels  input  [CHANNELS-1:0][ROWS*COLS-1:0] x PIX_W  frame; element k = row k/COLS, column k%COLS
delta  input  PIX_W  adjust step, sampled at accept
mode  input  2  00 contrast, 01 bypass, 10 soften, 11 treated as bypass; sampled at accept
out_valid  output  1  adjusted frame valid
out_ready  input  1  downstream ready
out_pixels  output  same shape as in_pixels  adjusted frame, registered

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid=0; out_pixels all 0; accumulators, row counter, captured frame/delta/mode cleared. in_ready=1 once rst_n is high.
- FSM IDLE -> ACCUM -> ADJUST -> OUT -> IDLE. in_ready is decoded from the state register (IDLE only).
- IDLE: on an edge with in_valid&&in_ready, capture in_pixels, delta and mode. Clear accumulators, set row=0, go to ACCUM.
- ACCUM: one row per cycle. For each channel c and tile b = col/BLK, acc[c][b] += sum of that row's BLK pixels in the tile. Accumulator width is PIX_W+log2(ROWS*BLK), so there is no overflow. After row ROWS-1, go to ADJUST.
- ADJUST, one cycle: avg = acc >> log2(ROWS*BLK) (floor). Per pixel p with tile avg a:
  - contrast: p>a gives min(p+delta, 2^PIX_W-1); p<=a gives max(p-delta, 0).
  - soften: p>a gives max(p-delta, 0); p<=a gives min(p+delta, 2^PIX_W-1).
  - bypass: p unchanged.
  - Compare is strictly greater than; equality takes the "<=" branch. Sums are formed at PIX_W+1 bits before clamping.
  - Register results into out_pixels, set out_valid=1, go to OUT.
- Latency: out_valid rises on the (ROWS+1)th rising edge after the accept edge (5 with defaults). Latency is identical for all modes; bypass still traverses ACCUM.
- OUT: out_valid and out_pixels are held stable while out_ready=0. On an edge with out_valid&&out_ready: out_valid becomes 0, go to IDLE. out_pixels keeps its last value (not cleared).
- No overlap: in_ready=0 from accept until the cycle after output handshake. in_valid in non-IDLE states is ignored and has no side effects.
- Changes on delta/mode after accept have no effect on the frame in flight.
- Reset asserted in any state aborts the frame immediately, with no output produced.

Test Plan:
- Reset -> out_valid=0, out_pixels all 0, in_ready=1 after release. Assert rst_n low mid-ACCUM -> FSM back in IDLE, and no out_valid ever appears for that frame.
- Contrast, delta=32: ch0 tile0 is fifteen 100s plus one 116 (k=0); sum 1616, avg 101 -> k=0 out 148, others 68; out_valid exactly 5 edges after accept.
- Saturation/equality, contrast, delta=32: tile of 240 x8 and 10 x8 (avg 125) -> 240->255, 10->0. Uniform tile of 200 -> all 168 (equality decrements).
- Soften delta=50 on the contrast frame above (avg 101) -> 116->66, 100->150. Bypass delta=32 -> out_pixels==in_pixels, latency still 5.
- Back-pressure: hold out_ready=0 for 10 cycles -> out_valid stays 1, out_pixels unchanged, in_ready=0, and a new in_valid is ignored. Raise out_ready -> out_valid 0 next edge, in_ready 1, and the next frame is accepted.
- Randomised: 20 back-to-back frames with random pixels, delta and mode, with random out_ready stalls -> every output matches a reference model using floor average and saturate.
